// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forward codes and result-source encodings for the hazard unit
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_MC = 2'b11;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - single-operand forward source priority (M, then W, then multi-cycle port)
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_w_i,
  input  logic              mc_wb_valid_i,
  input  logic [REG_AW-1:0] mc_wb_rd_i,
  output logic [1:0]        fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (rs_i != '0) begin
      if (reg_write_m_i && (rd_m_i == rs_i)) begin
        fwd_o = FWD_M;
      end else if (reg_write_w_i && (rd_w_i == rs_i)) begin
        fwd_o = FWD_W;
      end else if (mc_wb_valid_i && (mc_wb_rd_i == rs_i)) begin
        fwd_o = FWD_MC;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline hazard control with a scoreboard for the decoupled multi-cycle unit
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              McIssueE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              McWbValid,
  input  logic [REG_AW-1:0] McWbRd,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McAcceptE,
  output logic              McBusy,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int NUM_REGS = 1 << REG_AW;

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic lw_stall, sb_stall, struct_stall;
  logic raw1, raw2, waw;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_i          (Rs1E),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .mc_wb_valid_i (McWbValid),
    .mc_wb_rd_i    (McWbRd),
    .fwd_o         (ForwardAE)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_i          (Rs2E),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .mc_wb_valid_i (McWbValid),
    .mc_wb_rd_i    (McWbRd),
    .fwd_o         (ForwardBE)
  );

  // A writeback retiring the same register this cycle is bypassed, so it must not stall.
  always_comb begin
    raw1 = pend_q[Rs1D] && !(McWbValid && (McWbRd == Rs1D));
    raw2 = pend_q[Rs2D] && !(McWbValid && (McWbRd == Rs2D));
    waw  = RegWriteD && pend_q[RdD] && !(McWbValid && (McWbRd == RdD));
    sb_stall     = raw1 || raw2 || waw;
    lw_stall     = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                   ((Rs1D == RdE) || (Rs2D == RdE));
    struct_stall = McIssueE && busy_q && !McWbValid;
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    McAcceptE = McIssueE && !struct_stall && !PCSrcE;
    if (struct_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      StallF = lw_stall || sb_stall;
      StallD = lw_stall || sb_stall;
      FlushE = lw_stall || sb_stall || PCSrcE;
      FlushD = PCSrcE;
    end
  end

  always_comb begin
    pend_d = pend_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (McWbValid) begin
      pend_d[McWbRd] = 1'b0;
      busy_d         = 1'b0;
    end
    // Set after clear so a new issue to the retiring register keeps it pending.
    if (McAcceptE) begin
      if (RdE != '0) begin
        pend_d[RdE] = 1'b1;
      end
      busy_d = 1'b1;
    end
    pend_d[0] = 1'b0;
    if (StallF && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign McBusy     = busy_q;
  assign StallCount = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector table plus multi-cycle sequences for hazard_scoreboard
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, McWbRd;
  logic       RegWriteD, PCSrcE, McIssueE, RegWriteM, RegWriteW, McWbValid;
  logic [1:0] ResultSrcE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McAcceptE, McBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [15:0] StallCount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .McIssueE(McIssueE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .McWbValid(McWbValid), .McWbRd(McWbRd),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .McAcceptE(McAcceptE), .McBusy(McBusy), .StallCount(StallCount)
  );

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, mcrd;
    logic [1:0] rsrc;
    logic       pcsrc, wm, ww, mcv;
    logic       e_stall, e_flushd, e_flushe;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, McWbRd} = '0;
    {RegWriteD, PCSrcE, McIssueE, RegWriteM, RegWriteW, McWbValid} = '0;
    ResultSrcE = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string name, input logic s, input logic fd, input logic fe);
    chk({name, ".StallF"}, {15'd0, StallF}, {15'd0, s});
    chk({name, ".StallD"}, {15'd0, StallD}, {15'd0, s});
    chk({name, ".FlushD"}, {15'd0, FlushD}, {15'd0, fd});
    chk({name, ".FlushE"}, {15'd0, FlushE}, {15'd0, fe});
  endtask

  initial begin
    vec_t v;
    // Stall-free combinational vectors; stall vectors each add one to StallCount.
    v = '0; vecs.push_back(v);
    v = '0; v.rs1e = 5; v.rdm = 5; v.wm = 1; v.rdw = 5; v.ww = 1; v.e_fa = 2'b10; vecs.push_back(v);
    v = '0; v.rs1e = 5; v.rdm = 5; v.rdw = 5; v.ww = 1; v.e_fa = 2'b01; vecs.push_back(v);
    v = '0; v.rs1e = 0; v.rdm = 0; v.wm = 1; v.rdw = 0; v.ww = 1; v.mcv = 1; v.e_fa = 2'b00; vecs.push_back(v);
    v = '0; v.rs2e = 6; v.mcv = 1; v.mcrd = 6; v.e_fb = 2'b11; vecs.push_back(v);
    v = '0; v.rs1e = 3; v.rs2e = 3; v.rdm = 3; v.wm = 1; v.rdw = 3; v.ww = 1; v.mcv = 1; v.mcrd = 3;
    v.e_fa = 2'b10; v.e_fb = 2'b10; vecs.push_back(v);
    v = '0; v.rs2e = 8; v.rdw = 8; v.ww = 1; v.mcv = 1; v.mcrd = 8; v.e_fb = 2'b01; vecs.push_back(v);
    v = '0; v.rsrc = 2'b01; v.rde = 7; v.rs2d = 7; v.e_stall = 1; v.e_flushe = 1; vecs.push_back(v);
    v = '0; v.rsrc = 2'b01; v.rde = 0; v.rs1d = 0; vecs.push_back(v);
    v = '0; v.rsrc = 2'b00; v.rde = 7; v.rs2d = 7; vecs.push_back(v);
    v = '0; v.pcsrc = 1; v.e_flushd = 1; v.e_flushe = 1; vecs.push_back(v);
    v = '0; v.rsrc = 2'b01; v.rde = 7; v.rs1d = 7; v.pcsrc = 1;
    v.e_stall = 1; v.e_flushd = 1; v.e_flushe = 1; vecs.push_back(v);

    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset.StallF", {15'd0, StallF}, 16'd0);
    chk("reset.McBusy", {15'd0, McBusy}, 16'd0);
    chk("reset.StallCount", StallCount, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      v = vecs[i];
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
      RdM = v.rdm; RdW = v.rdw; McWbRd = v.mcrd; ResultSrcE = v.rsrc;
      PCSrcE = v.pcsrc; RegWriteM = v.wm; RegWriteW = v.ww; McWbValid = v.mcv;
      #1;
      chk_stall($sformatf("vec%0d", i), v.e_stall, v.e_flushd, v.e_flushe);
      chk($sformatf("vec%0d.ForwardAE", i), {14'd0, ForwardAE}, {14'd0, v.e_fa});
      chk($sformatf("vec%0d.ForwardBE", i), {14'd0, ForwardBE}, {14'd0, v.e_fb});
      chk($sformatf("vec%0d.StallE_FlushM", i), {14'd0, StallE, FlushM}, 16'd0);
      tick();
    end
    clear_inputs();
    #1;
    chk("table.StallCount", StallCount, 16'd2);

    // Issue to x9, RAW stall in decode until the writeback cycle.
    McIssueE = 1; RdE = 9; #1;
    chk("iss9.McAcceptE", {15'd0, McAcceptE}, 16'd1);
    tick();
    McIssueE = 0; RdE = 0; Rs1D = 9; #1;
    chk("iss9.McBusy", {15'd0, McBusy}, 16'd1);
    chk_stall("raw9a", 1, 0, 1);
    tick();
    chk_stall("raw9b", 1, 0, 1);
    tick();
    McWbValid = 1; McWbRd = 9; Rs1E = 9; #1;
    chk_stall("wb9", 0, 0, 0);
    chk("wb9.ForwardAE", {14'd0, ForwardAE}, 16'd3);
    tick();
    clear_inputs(); Rs1D = 9; #1;
    chk("post9.McBusy", {15'd0, McBusy}, 16'd0);
    chk_stall("post9", 0, 0, 0);
    chk("seqA.StallCount", StallCount, 16'd4);

    // Structural stall, then accept in the writeback cycle.
    clear_inputs(); McIssueE = 1; RdE = 10; #1;
    chk("iss10.McAcceptE", {15'd0, McAcceptE}, 16'd1);
    tick();
    RdE = 11; #1;
    chk("struct.McAcceptE", {15'd0, McAcceptE}, 16'd0);
    chk("struct.StallFDE", {13'd0, StallF, StallD, StallE}, 16'd7);
    chk("struct.FlushDEM", {13'd0, FlushD, FlushE, FlushM}, 16'd1);
    tick();
    McWbValid = 1; McWbRd = 10; #1;
    chk("b2b.McAcceptE", {15'd0, McAcceptE}, 16'd1);
    chk("b2b.StallF", {15'd0, StallF}, 16'd0);
    tick();
    McWbValid = 0; McIssueE = 0; RdE = 0; Rs2D = 11; #1;
    chk("b2b.McBusy", {15'd0, McBusy}, 16'd1);
    chk_stall("raw11", 1, 0, 1);
    Rs2D = 10; #1;
    chk_stall("nopend10", 0, 0, 0);
    Rs2D = 0;
    // Writeback of x11 and a new issue to x11 in the same cycle: set wins.
    McWbValid = 1; McWbRd = 11; McIssueE = 1; RdE = 11; Rs1D = 11; #1;
    chk("same.McAcceptE", {15'd0, McAcceptE}, 16'd1);
    chk_stall("mask11", 0, 0, 0);
    tick();
    clear_inputs(); RdD = 11; RegWriteD = 1; #1;
    chk_stall("waw11", 1, 0, 1);
    RegWriteD = 0; #1;
    chk_stall("nowrite11", 0, 0, 0);

    // WAW on x4, branch flush, then asynchronous reset mid-operation.
    clear_inputs(); McWbValid = 1; McWbRd = 11; McIssueE = 1; RdE = 4; #1;
    chk("iss4.McAcceptE", {15'd0, McAcceptE}, 16'd1);
    tick();
    clear_inputs(); RdD = 4; RegWriteD = 1; #1;
    chk_stall("waw4", 1, 0, 1);
    tick();
    PCSrcE = 1; #1;
    chk_stall("waw4br", 1, 1, 1);
    chk("pre_rst.StallCount", StallCount, 16'd6);
    PCSrcE = 0; #2;
    rst_n = 1'b0; #1;
    chk("rst.McBusy", {15'd0, McBusy}, 16'd0);
    chk("rst.StallCount", StallCount, 16'd0);
    chk_stall("rst", 0, 0, 0);
    tick();
    rst_n = 1'b1; McWbValid = 1; McWbRd = 4; #1;
    tick();
    McWbValid = 0; #1;
    chk("stray.McBusy", {15'd0, McBusy}, 16'd0);
    chk_stall("stray", 0, 0, 0);

    // Counter saturation.
    clear_inputs(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat.StallCount", StallCount, 16'hFFFF);
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
